// File: rtl/circuito_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// circuito_sweep_ctrl
//
// Exhaustive stimulus sequencer for the 9-input combinational block
// "circuito". It walks every input vector from 0 to 2^N_IN-1 and holds each
// one for SETTLE cycles so the block's output can settle. It then samples X
// for one cycle and accumulates:
//   - the number of vectors that gave X=1,
//   - the lowest vector that gave X=1,
//   - optionally, a MISR signature of the X stream.
//
// Optional feature macro: CIRCUITO_SWEEP_MISR_EN
//   When defined, sig_out carries a 16-bit MISR with polynomial
//   x^16+x^15+x^13+x^4+1. It is seeded with all ones when a sweep starts and
//   updated on every sample. When undefined, the MISR is absent and sig_out
//   is tied to zero.
//
// Parameters
//   N_IN    number of circuito inputs (vec_out[N_IN-1] = A ... vec_out[0] = I)
//   SETTLE  cycles each vector is held before sampling (>= 1)
//   SIG_W   MISR width (used only with CIRCUITO_SWEEP_MISR_EN; needs >= 16)
//
// Ports
//   clk            in   1        system clock, rising edge
//   rst_n          in   1        asynchronous active-low reset
//   start          in   1        start pulse, accepted only in IDLE or DONE
//   abort          in   1        terminates a sweep in progress; beats start
//   x_in           in   1        X output of circuito
//   vec_out        out  N_IN     registered drive to circuito {A..I}
//   busy           out  1        sweep in progress (SETTLE/SAMPLE)
//   done           out  1        sweep completed, held until the next start
//   ones_cnt       out  N_IN+1   count of sampled vectors with X=1
//   first_hit_vld  out  1        some vector with X=1 has been seen
//   first_hit_vec  out  N_IN     lowest vector with X=1
//   sig_out        out  SIG_W    MISR signature (zero when MISR absent)
// ---------------------------------------------------------------------------
module circuito_sweep_ctrl #(
    parameter int N_IN   = 9,
    parameter int SETTLE = 2,
    parameter int SIG_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              x_in,
    output logic [N_IN-1:0]   vec_out,
    output logic              busy,
    output logic              done,
    output logic [N_IN:0]     ones_cnt,
    output logic              first_hit_vld,
    output logic [N_IN-1:0]   first_hit_vec,
    output logic [SIG_W-1:0]  sig_out
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SET_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  VEC_ZERO  = {N_IN{1'b0}};
    localparam logic [N_IN-1:0]  VEC_ONE   = N_IN'(1);
    localparam logic [N_IN-1:0]  VEC_LAST  = {N_IN{1'b1}};
    localparam logic [N_IN:0]    ONES_ZERO = {(N_IN+1){1'b0}};
    localparam logic [N_IN:0]    ONES_ONE  = (N_IN+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [N_IN-1:0]   vec_r, vec_s;
    logic [CNT_W-1:0]  set_cnt_r, set_cnt_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [N_IN:0]     ones_cnt_r, ones_cnt_s;
    logic              first_hit_vld_r, first_hit_vld_s;
    logic [N_IN-1:0]   first_hit_vec_r, first_hit_vec_s;

`ifdef CIRCUITO_SWEEP_MISR_EN
    localparam logic [SIG_W-1:0] SIG_SEED = {SIG_W{1'b1}};

    logic [SIG_W-1:0]  sig_r, sig_s;

    // Feedback taps of x^16+x^15+x^13+x^4+1, folded with the sampled X.
    function automatic logic misr_fb(input logic [SIG_W-1:0] sig, input logic x);
        return sig[15] ^ sig[14] ^ sig[12] ^ sig[3] ^ x;
    endfunction

    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig, input logic x);
        return {sig[SIG_W-2:0], misr_fb(sig, x)};
    endfunction
`endif

    // Next-state and next-value logic for the sequencer and its accumulators.
    always_comb begin
        state_s         = state_r;
        vec_s           = vec_r;
        set_cnt_s       = set_cnt_r;
        ones_cnt_s      = ones_cnt_r;
        first_hit_vld_s = first_hit_vld_r;
        first_hit_vec_s = first_hit_vec_r;
`ifdef CIRCUITO_SWEEP_MISR_EN
        sig_s           = sig_r;
`endif
        busy_s          = 1'b0;
        done_s          = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                // abort suppresses a same-cycle start
                if (start && !abort) begin
                    state_s         = ST_SETTLE;
                    vec_s           = VEC_ZERO;
                    set_cnt_s       = CNT_ZERO;
                    ones_cnt_s      = ONES_ZERO;
                    first_hit_vld_s = 1'b0;
                    first_hit_vec_s = VEC_ZERO;
`ifdef CIRCUITO_SWEEP_MISR_EN
                    sig_s           = SIG_SEED;
`endif
                end else begin
                    state_s = state_r;
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    state_s   = ST_IDLE;
                    vec_s     = VEC_ZERO;
                    set_cnt_s = CNT_ZERO;
                end else if (set_cnt_r == SET_LAST) begin
                    state_s   = ST_SAMPLE;
                    set_cnt_s = CNT_ZERO;
                end else begin
                    set_cnt_s = set_cnt_r + CNT_ONE;
                end
            end

            ST_SAMPLE: begin
                // An abort here discards this vector's sample entirely.
                if (abort) begin
                    state_s   = ST_IDLE;
                    vec_s     = VEC_ZERO;
                    set_cnt_s = CNT_ZERO;
                end else begin
                    if (x_in) begin
                        ones_cnt_s = ones_cnt_r + ONES_ONE;
                        if (!first_hit_vld_r) begin
                            first_hit_vld_s = 1'b1;
                            first_hit_vec_s = vec_r;
                        end else begin
                            first_hit_vld_s = first_hit_vld_r;
                        end
                    end else begin
                        ones_cnt_s = ones_cnt_r;
                    end
`ifdef CIRCUITO_SWEEP_MISR_EN
                    sig_s = misr_next(sig_r, x_in);
`endif
                    // The terminal vector ends the sweep; vec never wraps.
                    if (vec_r == VEC_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s   = ST_SETTLE;
                        vec_s     = vec_r + VEC_ONE;
                        set_cnt_s = CNT_ZERO;
                    end
                end
            end

            default: begin
                state_s   = ST_IDLE;
                vec_s     = VEC_ZERO;
                set_cnt_s = CNT_ZERO;
            end
        endcase

        // Status flags are derived from the next state so they stay registered
        // yet line up with the state they describe.
        busy_s = (state_s == ST_SETTLE) || (state_s == ST_SAMPLE);
        done_s = (state_s == ST_DONE);
    end

    // State and accumulator registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            vec_r           <= VEC_ZERO;
            set_cnt_r       <= CNT_ZERO;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            ones_cnt_r      <= ONES_ZERO;
            first_hit_vld_r <= 1'b0;
            first_hit_vec_r <= VEC_ZERO;
        end else begin
            state_r         <= state_s;
            vec_r           <= vec_s;
            set_cnt_r       <= set_cnt_s;
            busy_r          <= busy_s;
            done_r          <= done_s;
            ones_cnt_r      <= ones_cnt_s;
            first_hit_vld_r <= first_hit_vld_s;
            first_hit_vec_r <= first_hit_vec_s;
        end
    end

`ifdef CIRCUITO_SWEEP_MISR_EN
    // Signature register, cleared to zero by reset and seeded on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= {SIG_W{1'b0}};
        end else begin
            sig_r <= sig_s;
        end
    end

    assign sig_out = sig_r;
`else
    assign sig_out = {SIG_W{1'b0}};
`endif

    assign vec_out       = vec_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign ones_cnt      = ones_cnt_r;
    assign first_hit_vld = first_hit_vld_r;
    assign first_hit_vec = first_hit_vec_r;

endmodule

// File: tb/tb_circuito_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for circuito_sweep_ctrl. A stand-in for circuito computes X from
// vec_out with one of several selectable functions, including a random truth
// table. The expected results for any number of completed vectors come from
// prefix tables built by plain iteration over the vector space. The expected
// timeline comes from the edge count since start was accepted.
// ---------------------------------------------------------------------------
module tb_circuito_sweep_ctrl;

    localparam int N_IN = 9;
    localparam int S    = 2;
    localparam int P    = S + 1;        // cycles per vector
    localparam int NV   = 1 << N_IN;    // number of vectors

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        x_in;
    logic [8:0]  vec_out;
    logic        busy;
    logic        done;
    logic [9:0]  ones_cnt;
    logic        first_hit_vld;
    logic [8:0]  first_hit_vec;
    logic [15:0] sig_out;

    int          fsel = 0;
    bit [511:0]  tt;

    int          checks   = 0;
    int          failures = 0;

    circuito_sweep_ctrl #(.N_IN(N_IN), .SETTLE(S), .SIG_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_in(x_in),
        .vec_out(vec_out), .busy(busy), .done(done), .ones_cnt(ones_cnt),
        .first_hit_vld(first_hit_vld), .first_hit_vec(first_hit_vec),
        .sig_out(sig_out)
    );

    always #5 clk = ~clk;

    // Stand-in for circuito: 0 = constant 0, 1 = AND, 2 = A, 3 = parity, else table
    function automatic bit fx(input int fs, input logic [8:0] v, input bit tbit);
        case (fs)
            0:       return 1'b0;
            1:       return &v;
            2:       return v[8];
            3:       return ^v;
            default: return tbit;
        endcase
    endfunction

    assign x_in = fx(fsel, vec_out, tt[vec_out]);

    // Prefix tables: results after the first n vectors have been sampled.
    int          pre_ones [0:NV];
    int          pre_first[0:NV];
    bit [15:0]   pre_sig  [0:NV];

    task automatic build_prefix();
        bit x;
        pre_ones[0]  = 0;
        pre_first[0] = -1;
        pre_sig[0]   = 16'hFFFF;
        for (int v = 0; v < NV; v++) begin
            x = fx(fsel, 9'(v), tt[v]);
            pre_ones[v+1]  = pre_ones[v] + int'(x);
            pre_first[v+1] = (pre_first[v] >= 0) ? pre_first[v] : (x ? v : -1);
            pre_sig[v+1]   = {pre_sig[v][14:0],
                              pre_sig[v][15] ^ pre_sig[v][14] ^ pre_sig[v][12] ^ pre_sig[v][3] ^ x};
        end
    endtask

    // {ones_cnt, first_hit_vld, first_hit_vec, sig_out} after n sampled vectors
    function automatic bit [35:0] res_of(input int n);
        bit [9:0]  o;
        bit        hv;
        bit [8:0]  hvec;
        bit [15:0] sg;
        o    = 10'(pre_ones[n]);
        hv   = (pre_first[n] >= 0);
        hvec = hv ? 9'(pre_first[n]) : 9'd0;
`ifdef CIRCUITO_SWEEP_MISR_EN
        sg   = pre_sig[n];
`else
        sg   = 16'h0000;
`endif
        return {o, hv, hvec, sg};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Timeline model: edges since accept while running, held values otherwise.
    bit        m_run;
    int        m_k;
    bit [8:0]  h_vec;
    bit        h_done;
    bit [35:0] h_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_k    <= 0;
            h_vec  <= 9'd0;
            h_done <= 1'b0;
            h_res  <= 36'd0;
        end else if (!m_run) begin
            if (start && !abort) begin
                m_run  <= 1'b1;
                m_k    <= 0;
                h_done <= 1'b0;
            end
        end else if (abort) begin
            // vectors whose sample edge came strictly before this one survive
            m_run  <= 1'b0;
            h_vec  <= 9'd0;
            h_done <= 1'b0;
            h_res  <= res_of(m_k / P);
        end else if (m_k + 1 == NV * P) begin
            m_run  <= 1'b0;
            h_vec  <= 9'(NV - 1);
            h_done <= 1'b1;
            h_res  <= res_of(NV);
        end else begin
            m_k <= m_k + 1;
        end
    end

    logic [46:0] cmp_exp;
    logic [46:0] cmp_act;

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            cmp_exp = m_run ? {9'(m_k / P), 1'b1, 1'b0, res_of(m_k / P)}
                            : {h_vec, 1'b0, h_done, h_res};
            cmp_act = {vec_out, busy, done, ones_cnt, first_hit_vld, first_hit_vec, sig_out};
            chk("cycle", 64'(cmp_act), 64'(cmp_exp));
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic prep(input int fs);
        @(posedge clk);
        #2;
        fsel = fs;
        build_prefix();
    endtask

    task automatic run_sweep(input int fs, input bit rs, output int cyc);
        bit got;
        prep(fs);
        do_start();
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (done) got = 1'b1;
            else start = rs ? ($urandom_range(0, 7) == 0) : 1'b0;
        end
        start = 1'b0;
        chk("sweep_done_seen", 64'(got), 64'd1);
    endtask

    task automatic abort_after(input int fs, input int w);
        prep(fs);
        do_start();
        repeat (w) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_vec",  64'(vec_out), 64'd0);
    endtask

    task automatic new_table();
        for (int i = 0; i < 16; i++) tt[i*32 +: 32] = $urandom();
    endtask

    int cyc;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tt    = '0;
        build_prefix();
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'({vec_out, busy, done, ones_cnt, first_hit_vld, first_hit_vec, sig_out}), 64'd0);
        rst_n = 1'b1;

        // constant-zero X: latency and empty results
        run_sweep(0, 1'b0, cyc);
        chk("latency", 64'(cyc), 64'd1536);
        chk("s1_done", 64'(done), 64'd1);
        chk("s1_ones", 64'(ones_cnt), 64'd0);
        chk("s1_fhv",  64'(first_hit_vld), 64'd0);
        chk("s1_vec",  64'(vec_out), 64'h1FF);

        // abort+start together in DONE, and abort alone in DONE: no effect
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        @(negedge clk);
        chk("done_abort_done", 64'(done), 64'd1);
        chk("done_abort_busy", 64'(busy), 64'd0);

        // AND gate
        run_sweep(1, 1'b1, cyc);
        chk("and_ones", 64'(ones_cnt), 64'd1);
        chk("and_fhv",  64'(first_hit_vld), 64'd1);
        chk("and_fhvec", 64'(first_hit_vec), 64'h1FF);

        // A only
        run_sweep(2, 1'b1, cyc);
        chk("a_ones",  64'(ones_cnt), 64'd256);
        chk("a_fhvec", 64'(first_hit_vec), 64'h100);

        // abort at cycle 100, then a full re-run
        abort_after(2, 100);
        run_sweep(2, 1'b0, cyc);
        chk("rerun_ones",  64'(ones_cnt), 64'd256);
        chk("rerun_fhvec", 64'(first_hit_vec), 64'h100);

        // asynchronous reset in the middle of a sweep
        prep(3);
        do_start();
        repeat (700) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 64'({vec_out, busy, done, ones_cnt, first_hit_vld, first_hit_vec, sig_out}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // parity after reset recovery
        run_sweep(3, 1'b0, cyc);
        chk("par_ones",  64'(ones_cnt), 64'd256);
        chk("par_fhvec", 64'(first_hit_vec), 64'h001);
`ifdef CIRCUITO_SWEEP_MISR_EN
        chk("par_sig", 64'(sig_out), 64'(pre_sig[NV]));
`else
        chk("par_sig", 64'(sig_out), 64'd0);
`endif

        // random truth tables, full sweeps with stray start pulses
        for (int r = 0; r < 3; r++) begin
            new_table();
            run_sweep(4, 1'b1, cyc);
            chk("rand_latency", 64'(cyc), 64'd1536);
            chk("rand_ones", 64'(ones_cnt), 64'(pre_ones[NV]));
        end

        // random abort points, plus abort in the final SAMPLE cycle
        for (int r = 0; r < 3; r++) begin
            new_table();
            abort_after(4, $urandom_range(0, 1534));
        end
        abort_after(4, 1535);

        // abort alone in IDLE has no effect
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", 64'(busy), 64'd0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
